ccm_mem_arbiter: RTL and testbench

CCM_MEM_ARBITER -- requirements
Module: ccm_mem_arbiter

---
 rtl/ccm_mem_arbiter_pkg.sv | 36 +++
 rtl/ccm_mem_arbiter_if.sv | 29 ++
 rtl/ccm_mem_arbiter_rr_pick.sv | 33 +++
 rtl/ccm_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ccm_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ccm_mem_arbiter_pkg.sv
// Shared definitions for the CCM memory arbiter: FSM encoding, command
// field positions, error code values and requester indices.
package ccm_mem_arbiter_pkg;

  // Arbiter FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ISSUE = 2'd2,
    ST_BUSY  = 2'd3
  } arb_state_e;

  // Command word layout: bit3 = write, bits2:0 = beats-1.
  localparam int CMD_W         = 4;
  localparam int ADDR_W        = 32;
  localparam int CMD_WR_BIT    = 3;
  localparam int CMD_BEATS_MSB = 2;
  localparam int CMD_BEATS_LSB = 0;
  localparam int BEAT_CNT_W    = 4;

  // Sticky error code bits.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BEAT    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Requester slot indices.
  localparam int REQ_KERNEL = 0;
  localparam int REQ_FMAP   = 1;
  localparam int REQ_OUTPUT = 2;

  // Number of beats a command asks for (beats-1 field plus one).
  function automatic logic [BEAT_CNT_W-1:0] cmd_beats(input logic [CMD_W-1:0] cmd);
    return {1'b0, cmd[CMD_BEATS_MSB:CMD_BEATS_LSB]} + 4'd1;
  endfunction

endpackage

// File: rtl/ccm_mem_arbiter_if.sv
// Requester and memory buses of the CCM arbiter. The arbiter uses the
// master view; requesters and the memory model use the slave view.
interface ccm_mem_arbiter_if
  import ccm_mem_arbiter_pkg::*;
#(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]        req;
  logic [CMD_W*N_REQ-1:0]  req_cmd;
  logic [ADDR_W*N_REQ-1:0] req_addr;
  logic [N_REQ-1:0]        sel;
  logic [N_REQ-1:0]        req_vld;
  logic [N_REQ-1:0]        req_fin;
  logic                    mem_req;
  logic [CMD_W-1:0]        mem_cmd;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_vld;
  logic                    mem_fin;

  modport master (
    input  req, req_cmd, req_addr, mem_vld, mem_fin,
    output sel, req_vld, req_fin, mem_req, mem_cmd, mem_addr
  );

  modport slave (
    output req, req_cmd, req_addr, mem_vld, mem_fin,
    input  sel, req_vld, req_fin, mem_req, mem_cmd, mem_addr
  );
endinterface

// File: rtl/ccm_mem_arbiter_rr_pick.sv
// Combinational round-robin selector: searches req starting one slot
// after ptr (wrapping) and returns a one-hot winner plus a valid flag.
module ccm_mem_arbiter_rr_pick #(
  parameter int N_REQ = 3,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic             valid
);

  // First requesting slot at ptr+1, ptr+2, ... (mod N_REQ) wins.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          take;
    grant = {N_REQ{1'b0}};
    valid = 1'b0;
    sum   = {(PW+1){1'b0}};
    idx   = {PW{1'b0}};
    take  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum        = {1'b0, ptr} + (PW+1)'(k);
      sum        = (sum >= (PW+1)'(N_REQ)) ? sum - (PW+1)'(N_REQ) : sum;
      idx        = sum[PW-1:0];
      take       = req[idx] & ~valid;
      grant[idx] = grant[idx] | take;
      valid      = valid | take;
    end
  end

endmodule

// File: rtl/ccm_mem_arbiter.sv
// CCM memory arbiter: round-robin grant among N_REQ requesters, one
// command strobe per burst, beat counting and a BUSY watchdog with a
// sticky error code.
module ccm_mem_arbiter
  import ccm_mem_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int TO_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  ccm_mem_arbiter_if.master bus,
  input  logic [TO_W-1:0]   cfg_timeout,
  input  logic              err_clr,
  output logic [1:0]        err_code
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW-1:0] PTR_INIT = PW'(N_REQ - 1);

  arb_state_e              state_r, state_s;
  logic [PW-1:0]           ptr_r, ptr_s;
  logic [N_REQ-1:0]        sel_r, sel_s;
  logic                    mem_req_r, mem_req_s;
  logic [CMD_W-1:0]        mem_cmd_r, mem_cmd_s;
  logic [ADDR_W-1:0]       mem_addr_r, mem_addr_s;
  logic [BEAT_CNT_W-1:0]   beat_r, beat_s, beat_inc_s;
  logic [TO_W-1:0]         wdog_r, wdog_s;
  logic [TO_W:0]           wdog_inc_s;
  logic [1:0]              err_r, err_s, err_set_s;
  logic                    timeout_s;
  logic [N_REQ-1:0]        pick_grant_s;
  logic                    pick_valid_s;
  logic [CMD_W-1:0]        win_cmd_s;
  logic [ADDR_W-1:0]       win_addr_s;
  logic [PW-1:0]           win_idx_s;

  ccm_mem_arbiter_rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_rr_pick (
    .req   (bus.req),
    .ptr   (ptr_r),
    .grant (pick_grant_s),
    .valid (pick_valid_s)
  );

  // Command, address and index of the currently granted requester.
  always_comb begin
    win_cmd_s  = {CMD_W{1'b0}};
    win_addr_s = {ADDR_W{1'b0}};
    win_idx_s  = {PW{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      win_cmd_s  = win_cmd_s  | (sel_r[i] ? bus.req_cmd[i*CMD_W +: CMD_W]    : {CMD_W{1'b0}});
      win_addr_s = win_addr_s | (sel_r[i] ? bus.req_addr[i*ADDR_W +: ADDR_W] : {ADDR_W{1'b0}});
      win_idx_s  = win_idx_s  | (sel_r[i] ? PW'(i) : {PW{1'b0}});
    end
  end

  // Saturating beat count including this cycle's beat; watchdog including this cycle.
  always_comb begin
    beat_inc_s = (beat_r == {BEAT_CNT_W{1'b1}}) ? beat_r : beat_r + {{(BEAT_CNT_W-1){1'b0}}, bus.mem_vld};
    wdog_inc_s = {1'b0, wdog_r} + {{TO_W{1'b0}}, 1'b1};
    timeout_s  = (cfg_timeout != {TO_W{1'b0}}) && (wdog_inc_s == {1'b0, cfg_timeout});
  end

  // Next-state and next-register logic. MEM_FIN beats the watchdog when both occur together.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    sel_s      = sel_r;
    mem_req_s  = 1'b0;
    mem_cmd_s  = mem_cmd_r;
    mem_addr_s = mem_addr_r;
    beat_s     = beat_r;
    wdog_s     = wdog_r;
    err_set_s  = ERR_NONE;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          sel_s   = pick_grant_s;
          state_s = ST_GRANT;
        end else begin
          sel_s   = {N_REQ{1'b0}};
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        mem_cmd_s  = win_cmd_s;
        mem_addr_s = win_addr_s;
        beat_s     = {BEAT_CNT_W{1'b0}};
        wdog_s     = {TO_W{1'b0}};
        state_s    = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_req_s = 1'b1;
        state_s   = ST_BUSY;
      end
      ST_BUSY: begin
        beat_s = beat_inc_s;
        wdog_s = wdog_inc_s[TO_W-1:0];
        if (bus.mem_fin) begin
          err_set_s = (beat_inc_s != cmd_beats(mem_cmd_r)) ? ERR_BEAT : ERR_NONE;
          sel_s     = {N_REQ{1'b0}};
          ptr_s     = win_idx_s;
          state_s   = ST_IDLE;
        end else if (timeout_s) begin
          err_set_s = ERR_TIMEOUT;
          sel_s     = {N_REQ{1'b0}};
          ptr_s     = win_idx_s;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      default: begin
        sel_s   = {N_REQ{1'b0}};
        state_s = ST_IDLE;
      end
    endcase
    // A bit being set this cycle survives a simultaneous clear.
    err_s = (err_clr ? ERR_NONE : err_r) | err_set_s;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r      <= PTR_INIT;
      sel_r      <= {N_REQ{1'b0}};
      mem_req_r  <= 1'b0;
      mem_cmd_r  <= {CMD_W{1'b0}};
      mem_addr_r <= {ADDR_W{1'b0}};
      beat_r     <= {BEAT_CNT_W{1'b0}};
      wdog_r     <= {TO_W{1'b0}};
      err_r      <= ERR_NONE;
    end else begin
      ptr_r      <= ptr_s;
      sel_r      <= sel_s;
      mem_req_r  <= mem_req_s;
      mem_cmd_r  <= mem_cmd_s;
      mem_addr_r <= mem_addr_s;
      beat_r     <= beat_s;
      wdog_r     <= wdog_s;
      err_r      <= err_s;
    end
  end

  assign bus.sel      = sel_r;
  assign bus.mem_req  = mem_req_r;
  assign bus.mem_cmd  = mem_cmd_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.req_vld  = {N_REQ{bus.mem_vld}} & sel_r;
  assign bus.req_fin  = {N_REQ{bus.mem_fin}} & sel_r;
  assign err_code     = err_r;

endmodule

// File: tb/tb_ccm_mem_arbiter.sv
// Self-checking bench for ccm_mem_arbiter: directed scenarios plus a
// randomized loop checked against a round-robin reference model.
module tb_ccm_mem_arbiter;
  localparam int N  = 3;
  localparam int TW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [TW-1:0] cfg_timeout;
  logic          err_clr;
  logic [1:0]    err_code;

  ccm_mem_arbiter_if #(.N_REQ(N)) bus ();

  ccm_mem_arbiter #(.N_REQ(N), .TO_W(TW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cfg_timeout(cfg_timeout), .err_clr(err_clr), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int ptr_m;
  logic [3:0]  cmd_m [N];
  logic [31:0] addr_m [N];
  int obs_vld [N];
  int obs_fin [N];
  int obs_req;

  // Reference round-robin: first requester after the last winner, wrapping.
  function automatic int rr_model(input logic [N-1:0] r, input int p);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (p + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_slot(input int i, input logic [3:0] c, input logic [31:0] a);
    cmd_m[i] = c; addr_m[i] = a;
    bus.req_cmd[i*4 +: 4]   = c;
    bus.req_addr[i*32 +: 32] = a;
  endtask

  task automatic apply_reset();
    rst = 1'b1; bus.req = '0; bus.mem_vld = 1'b0; bus.mem_fin = 1'b0; err_clr = 1'b0;
    cyc(); cyc();
    rst = 1'b0; cyc();
    ptr_m = N - 1;
  endtask

  task automatic wait_grant(output int gidx, output int lat, output logic [N-1:0] gsel);
    gidx = -1; lat = 0; gsel = '0;
    for (int i = 0; i < 20; i++) begin
      if (bus.sel != '0) begin
        gsel = bus.sel;
        for (int j = 0; j < N; j++) if (bus.sel[j]) gidx = j;
        break;
      end
      cyc(); lat++;
    end
  endtask

  task automatic wait_strobe(output bit found, output int lat, output logic [3:0] c, output logic [31:0] a);
    found = 1'b0; lat = 0; c = '0; a = '0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_req) begin
        found = 1'b1; c = bus.mem_cmd; a = bus.mem_addr;
        break;
      end
      cyc(); lat++;
    end
  endtask

  task automatic tally();
    for (int i = 0; i < N; i++) begin
      obs_vld[i] += int'(bus.req_vld[i]);
      obs_fin[i] += int'(bus.req_fin[i]);
    end
    obs_req += int'(bus.mem_req);
  endtask

  // Memory model: nbeats data beats, FIN either with the last beat or one cycle later.
  task automatic serve(input int nbeats, input bit fin_same);
    for (int i = 0; i < N; i++) begin obs_vld[i] = 0; obs_fin[i] = 0; end
    obs_req = 0;
    for (int b = 0; b < nbeats; b++) begin
      bus.mem_vld = 1'b1;
      bus.mem_fin = fin_same && (b == nbeats - 1);
      #1 tally(); cyc();
    end
    if (!fin_same || nbeats == 0) begin
      bus.mem_vld = 1'b0; bus.mem_fin = 1'b1;
      #1 tally(); cyc();
    end
    bus.mem_vld = 1'b0; bus.mem_fin = 1'b0;
  endtask

  task automatic test_reset();
    int nreq;
    apply_reset();
    chk_cnt++; if (bus.sel !== 3'b000) $display("FAIL reset_sel: got %b exp 000", bus.sel); else pass_cnt++;
    chk_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b exp 0", bus.mem_req); else pass_cnt++;
    chk_cnt++; if (bus.mem_cmd !== 4'h0) $display("FAIL reset_mem_cmd: got %h exp 0", bus.mem_cmd); else pass_cnt++;
    chk_cnt++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h exp 0", bus.mem_addr); else pass_cnt++;
    chk_cnt++; if (err_code !== 2'b00) $display("FAIL reset_err: got %b exp 00", err_code); else pass_cnt++;
    nreq = 0;
    for (int i = 0; i < 4; i++) begin nreq += int'(bus.mem_req); cyc(); end
    chk_cnt++; if (nreq !== 0) $display("FAIL reset_idle_strobe: got %0d exp 0", nreq); else pass_cnt++;
  endtask

  task automatic test_single();
    int gidx, lg, ls; logic [N-1:0] gs; bit found; logic [3:0] c; logic [31:0] a;
    // Memory activity while IDLE must be ignored.
    bus.mem_vld = 1'b1; bus.mem_fin = 1'b1; cyc(); cyc();
    bus.mem_vld = 1'b0; bus.mem_fin = 1'b0;
    chk_cnt++; if (err_code !== 2'b00) $display("FAIL idle_fin_ignored: got %b exp 00", err_code); else pass_cnt++;
    set_slot(0, 4'h3, 32'h100);
    bus.req = 3'b001;
    wait_grant(gidx, lg, gs);
    chk_cnt++; if (gs !== 3'b001) $display("FAIL single_sel: got %b exp 001", gs); else pass_cnt++;
    chk_cnt++; if (lg !== 1) $display("FAIL single_sel_latency: got %0d exp 1", lg); else pass_cnt++;
    wait_strobe(found, ls, c, a);
    chk_cnt++; if (!found || (lg + ls) !== 3) $display("FAIL single_strobe_latency: got found=%0d lat=%0d exp 3", found, lg + ls); else pass_cnt++;
    chk_cnt++; if (c !== 4'h3 || a !== 32'h100) $display("FAIL single_cmd_addr: got %h/%h exp 3/100", c, a); else pass_cnt++;
    serve(4, 1'b0);
    bus.req = '0;
    chk_cnt++; if (obs_vld[0] !== 4 || obs_vld[1] !== 0 || obs_vld[2] !== 0) $display("FAIL single_req_vld: got %0d,%0d,%0d exp 4,0,0", obs_vld[0], obs_vld[1], obs_vld[2]); else pass_cnt++;
    chk_cnt++; if (obs_req !== 1) $display("FAIL single_strobe_count: got %0d exp 1", obs_req); else pass_cnt++;
    chk_cnt++; if (err_code !== 2'b00 || bus.sel !== 3'b000) $display("FAIL single_end: got err=%b sel=%b exp 00/000", err_code, bus.sel); else pass_cnt++;
    ptr_m = 0;
  endtask

  task automatic test_fairness();
    int order [6] = '{0, 1, 2, 0, 1, 2};
    int gidx, lg, ls; logic [N-1:0] gs; bit found; logic [3:0] c; logic [31:0] a;
    apply_reset();
    for (int i = 0; i < N; i++) set_slot(i, 4'h1, 32'h1000 + 32'(i * 16));
    bus.req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      wait_grant(gidx, lg, gs);
      chk_cnt++; if (gidx !== order[t] || gidx !== rr_model(3'b111, ptr_m)) $display("FAIL fair_order_%0d: got %0d exp %0d", t, gidx, order[t]); else pass_cnt++;
      chk_cnt++; if (lg !== 1) $display("FAIL fair_back_to_back_%0d: got gap %0d exp 1", t, lg); else pass_cnt++;
      wait_strobe(found, ls, c, a);
      serve(2, 1'($urandom_range(0, 1)));
      ptr_m = order[t];
    end
    bus.req = '0;
    chk_cnt++; if (err_code !== 2'b00) $display("FAIL fair_err: got %b exp 00", err_code); else pass_cnt++;
  endtask

  task automatic test_mismatch();
    int gidx, lg, ls; logic [N-1:0] gs; bit found; logic [3:0] c; logic [31:0] a;
    set_slot(0, 4'h3, 32'h200);
    bus.req = 3'b001;
    wait_grant(gidx, lg, gs);
    wait_strobe(found, ls, c, a);
    serve(3, 1'b0);
    bus.req = '0;
    chk_cnt++; if (err_code !== 2'b01) $display("FAIL mismatch_err: got %b exp 01", err_code); else pass_cnt++;
    chk_cnt++; if (bus.sel !== 3'b000) $display("FAIL mismatch_sel: got %b exp 000", bus.sel); else pass_cnt++;
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    chk_cnt++; if (err_code !== 2'b00) $display("FAIL mismatch_clear: got %b exp 00", err_code); else pass_cnt++;
    // Clear held across a mismatching FIN: the bit being set wins.
    bus.req = 3'b001;
    wait_grant(gidx, lg, gs);
    wait_strobe(found, ls, c, a);
    err_clr = 1'b1;
    serve(2, 1'b1);
    err_clr = 1'b0; bus.req = '0;
    chk_cnt++; if (err_code !== 2'b01) $display("FAIL clear_vs_set: got %b exp 01", err_code); else pass_cnt++;
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    ptr_m = 0;
  endtask

  task automatic test_timeout();
    int gidx, lg, ls; logic [N-1:0] gs; bit found; logic [3:0] c; logic [31:0] a;
    cfg_timeout = 10'd20;
    set_slot(0, 4'h7, 32'h300);
    bus.req = 3'b001;
    wait_grant(gidx, lg, gs);
    wait_strobe(found, ls, c, a);
    for (int i = 1; i < 20; i++) cyc();
    chk_cnt++; if (err_code !== 2'b00 || bus.sel !== 3'b001) $display("FAIL timeout_early: got err=%b sel=%b exp 00/001", err_code, bus.sel); else pass_cnt++;
    cyc();
    chk_cnt++; if (err_code !== 2'b10) $display("FAIL timeout_err: got %b exp 10", err_code); else pass_cnt++;
    chk_cnt++; if (bus.sel !== 3'b000) $display("FAIL timeout_sel: got %b exp 000", bus.sel); else pass_cnt++;
    bus.req = '0; cfg_timeout = '0;
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    chk_cnt++; if (err_code !== 2'b00) $display("FAIL timeout_clear: got %b exp 00", err_code); else pass_cnt++;
    ptr_m = 0;
  endtask

  task automatic test_reset_busy();
    int gidx, lg, ls, nreq; logic [N-1:0] gs; bit found; logic [3:0] c; logic [31:0] a;
    set_slot(1, 4'h7, 32'h400);
    bus.req = 3'b010;
    wait_grant(gidx, lg, gs);
    chk_cnt++; if (gidx !== rr_model(3'b010, ptr_m)) $display("FAIL rstbusy_grant: got %0d exp 1", gidx); else pass_cnt++;
    wait_strobe(found, ls, c, a);
    bus.mem_vld = 1'b1; cyc(); cyc();
    rst = 1'b1; #1;
    chk_cnt++; if (bus.sel !== 3'b000 || bus.mem_req !== 1'b0) $display("FAIL rstbusy_sel_req: got %b/%b exp 000/0", bus.sel, bus.mem_req); else pass_cnt++;
    chk_cnt++; if (bus.mem_cmd !== 4'h0 || bus.mem_addr !== 32'h0 || err_code !== 2'b00) $display("FAIL rstbusy_regs: got %h/%h/%b exp 0/0/00", bus.mem_cmd, bus.mem_addr, err_code); else pass_cnt++;
    chk_cnt++; if (bus.req_vld !== 3'b000) $display("FAIL rstbusy_req_vld: got %b exp 000", bus.req_vld); else pass_cnt++;
    bus.mem_vld = 1'b0; bus.req = '0; cyc();
    rst = 1'b0; ptr_m = N - 1;
    nreq = 0;
    for (int i = 0; i < 4; i++) begin nreq += int'(bus.mem_req); cyc(); end
    chk_cnt++; if (nreq !== 0) $display("FAIL rstbusy_no_strobe: got %0d exp 0", nreq); else pass_cnt++;
    set_slot(0, 4'h0, 32'h500);
    bus.req = 3'b111;
    wait_grant(gidx, lg, gs);
    chk_cnt++; if (gidx !== 0) $display("FAIL rstbusy_first_grant: got %0d exp 0", gidx); else pass_cnt++;
    wait_strobe(found, ls, c, a);
    serve(1, 1'b1);
    bus.req = '0; ptr_m = 0;
  endtask

  task automatic test_isolation();
    int gidx, lg, ls; logic [N-1:0] gs; bit found; logic [3:0] c; logic [31:0] a;
    apply_reset();
    set_slot(1, 4'h3, 32'h600);
    set_slot(2, 4'h2, 32'h700);
    bus.req = 3'b110;
    wait_grant(gidx, lg, gs);
    chk_cnt++; if (gidx !== 1) $display("FAIL iso_grant: got %0d exp 1", gidx); else pass_cnt++;
    wait_strobe(found, ls, c, a);
    serve(4, 1'b0);
    bus.req = '0;
    chk_cnt++; if (obs_vld[2] !== 0 || obs_fin[2] !== 0) $display("FAIL iso_req2: got vld=%0d fin=%0d exp 0/0", obs_vld[2], obs_fin[2]); else pass_cnt++;
    chk_cnt++; if (obs_vld[1] !== 4 || obs_fin[1] !== 1) $display("FAIL iso_req1: got vld=%0d fin=%0d exp 4/1", obs_vld[1], obs_fin[1]); else pass_cnt++;
    ptr_m = 1;
  endtask

  task automatic test_random();
    int gidx, lg, ls, exp, good, nb, others; logic [N-1:0] gs, r; bit found;
    logic [3:0] c; logic [31:0] a; logic [1:0] exp_err;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) set_slot(i, 4'($urandom_range(0, 15)), $urandom);
      r = 3'($urandom_range(1, 7));
      exp = rr_model(r, ptr_m);
      bus.req = r;
      wait_grant(gidx, lg, gs);
      chk_cnt++; if (gidx !== exp || lg !== 1) $display("FAIL rand_grant_%0d: got %0d lat %0d exp %0d lat 1", it, gidx, lg, exp); else pass_cnt++;
      wait_strobe(found, ls, c, a);
      chk_cnt++; if (!found || c !== cmd_m[exp] || a !== addr_m[exp]) $display("FAIL rand_cmd_%0d: got %h/%h exp %h/%h", it, c, a, cmd_m[exp], addr_m[exp]); else pass_cnt++;
      if ($urandom_range(0, 1) == 1) bus.req[exp] = 1'b0;
      good = int'(cmd_m[exp][2:0]) + 1;
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : good;
      exp_err = (nb != good) ? 2'b01 : 2'b00;
      serve(nb, 1'($urandom_range(0, 1)));
      bus.req = '0;
      others = 0;
      for (int i = 0; i < N; i++) if (i != exp) others += obs_vld[i] + obs_fin[i];
      chk_cnt++; if (obs_vld[exp] !== nb || obs_fin[exp] !== 1 || others !== 0) $display("FAIL rand_beats_%0d: got vld=%0d fin=%0d other=%0d exp %0d/1/0", it, obs_vld[exp], obs_fin[exp], others, nb); else pass_cnt++;
      chk_cnt++; if (err_code !== exp_err || bus.sel !== 3'b000 || obs_req !== 1) $display("FAIL rand_end_%0d: got err=%b sel=%b strobes=%0d exp %b/000/1", it, err_code, bus.sel, obs_req, exp_err); else pass_cnt++;
      ptr_m = exp;
      err_clr = 1'b1; cyc(); err_clr = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; cfg_timeout = '0; err_clr = 1'b0;
    bus.req = '0; bus.req_cmd = '0; bus.req_addr = '0;
    bus.mem_vld = 1'b0; bus.mem_fin = 1'b0;
    for (int i = 0; i < N; i++) begin cmd_m[i] = '0; addr_m[i] = '0; end
    test_reset();
    test_single();
    test_fairness();
    test_mismatch();
    test_timeout();
    test_reset_busy();
    test_isolation();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no finish exp finish within 500us");
    $fatal(1);
  end

endmodule
